// File: rtl/mem_wb_elastic_reg_if.sv
// Handshake bundle for one elastic pipeline-stage boundary: upstream offer,
// downstream consume, flush and the back-pressure counter.
interface mem_wb_elastic_reg_if #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  // The elastic register itself.
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

  // The surrounding pipeline (or a bench) driving and observing it.
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );
endinterface

// File: rtl/mem_wb_elastic_reg.sv
// Elastic MEM->WB pipeline register: main + skid entry, synchronous flush,
// zeroed control on bubbles and a saturating back-pressure counter.
module mem_wb_elastic_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_wb_elastic_reg_if.slave  bus,
  output logic [1:0]           dbg_state
);

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; an unaccepted offer must be held stable by its source.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              main_v;
  logic              skid_v;
  logic              acc;
  logic              pop;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  stall_q;

  // The state encoding is the pair of valid bits itself.
  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  assign acc = bus.in_valid & ~skid_v;
  assign pop = main_v & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (acc && pop) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers are never cleared by flush; only valid bits are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= bus.in_ctrl;
        main_data <= bus.in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= bus.in_ctrl;
        skid_data <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.in_valid && skid_v && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = main_v;
  // Bubbles carry all-zero control so they can never cause a register write.
  assign bus.out_ctrl  = main_v ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.stall_cnt = stall_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Bench for mem_wb_elastic_reg: directed vector table, a random-backpressure
// ordering scoreboard, counter saturation and asynchronous reset sequences.
module tb_mem_wb_elastic_reg;

  localparam int DW = 69;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state4;

  mem_wb_elastic_reg_if #(.DATA_W(DW), .CTRL_W(2), .CNT_W(16)) bus ();
  mem_wb_elastic_reg_if #(.DATA_W(DW), .CTRL_W(2), .CNT_W(4))  bus4 ();

  mem_wb_elastic_reg #(.DATA_W(DW), .CTRL_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
  );

  mem_wb_elastic_reg #(.DATA_W(DW), .CTRL_W(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .dbg_state(dbg_state4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          iv;
    logic [1:0]    ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [1:0]    ec;
    logic [DW-1:0] ed;
    logic          erdy;
    logic [15:0]   es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [1:0] ic, logic [DW-1:0] id, logic ordy, logic fl,
                              logic ev, logic [1:0] ec, logic [DW-1:0] ed, logic erdy, logic [15:0] es);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ed = ed; v.erdy = erdy; v.es = es;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic iv, input logic [1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_ctrl   = ic;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic drive4(input logic iv, input logic [DW-1:0] id, input logic ordy);
    bus4.in_valid  = iv;
    bus4.in_ctrl   = 2'b01;
    bus4.in_data   = id;
    bus4.out_ready = ordy;
    bus4.flush     = 1'b0;
  endtask

  // scoreboard
  logic [DW-1:0] exp_q[$];

  initial begin
    int sent;
    int got;
    logic holding;
    logic [DW-1:0] exp_d;

    rst = 1'b1;
    drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
    drive4(1'b0, '0, 1'b0);
    #1;
    check("rst_out_valid", DW'(bus.out_valid), DW'(0));
    check("rst_in_ready",  DW'(bus.in_ready),  DW'(1));
    check("rst_out_ctrl",  DW'(bus.out_ctrl),  DW'(0));
    check("rst_out_data",  bus.out_data,       DW'(0));
    check("rst_stall_cnt", DW'(bus.stall_cnt), DW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // streaming: 8 beats, 1-cycle latency, in_ready stays high
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 2'b11, DW'(16 + i), 1, 0, 1, 2'b11, DW'(16 + i), 1, 0));
    vecs.push_back(mk(0, 2'b00, '0, 1, 0, 0, 2'b00, DW'(16 + 7), 1, 0));
    // back-pressure: A then B fill FULL, three stalled cycles, then drain in order
    vecs.push_back(mk(1, 2'b01, DW'(1), 0, 0, 1, 2'b01, DW'(1), 1, 0));
    vecs.push_back(mk(1, 2'b10, DW'(2), 0, 0, 1, 2'b01, DW'(1), 0, 0));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(1, 2'b10, DW'(2), 0, 0, 1, 2'b01, DW'(1), 0, 16'(k)));
    vecs.push_back(mk(0, 2'b00, '0, 1, 0, 1, 2'b10, DW'(2), 1, 3));
    vecs.push_back(mk(0, 2'b00, '0, 1, 0, 0, 2'b00, DW'(2), 1, 3));
    // flush in FULL with a stalled offer of 0x3 (the offer still counts as a stall)
    vecs.push_back(mk(1, 2'b11, DW'(4), 0, 0, 1, 2'b11, DW'(4), 1, 3));
    vecs.push_back(mk(1, 2'b11, DW'(5), 0, 0, 1, 2'b11, DW'(4), 0, 3));
    vecs.push_back(mk(1, 2'b01, DW'(3), 0, 1, 0, 2'b00, DW'(4), 1, 4));
    vecs.push_back(mk(0, 2'b00, '0, 1, 0, 0, 2'b00, DW'(4), 1, 4));
    vecs.push_back(mk(0, 2'b00, '0, 1, 0, 0, 2'b00, DW'(4), 1, 4));
    // flush in ONE together with an accepted beat: beat dropped, EMPTY after
    vecs.push_back(mk(1, 2'b10, DW'(6), 0, 0, 1, 2'b10, DW'(6), 1, 4));
    vecs.push_back(mk(1, 2'b01, DW'(7), 1, 1, 0, 2'b00, DW'(6), 1, 4));
    vecs.push_back(mk(0, 2'b00, '0, 1, 0, 0, 2'b00, DW'(6), 1, 4));
    // bubble control: one ctrl=01 beat, then four bubbles hold data, zero ctrl
    vecs.push_back(mk(1, 2'b01, DW'(85), 1, 0, 1, 2'b01, DW'(85), 1, 4));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 2'b00, '0, 1, 0, 0, 2'b00, DW'(85), 1, 4));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), DW'(bus.out_valid), DW'(vecs[i].ev));
      check($sformatf("v%0d_out_ctrl", i),  DW'(bus.out_ctrl),  DW'(vecs[i].ec));
      check($sformatf("v%0d_out_data", i),  bus.out_data,       vecs[i].ed);
      check($sformatf("v%0d_in_ready", i),  DW'(bus.in_ready),  DW'(vecs[i].erdy));
      check($sformatf("v%0d_stall_cnt", i), DW'(bus.stall_cnt), DW'(vecs[i].es));
    end

    // ordering under random back-pressure: 20 beats must leave in order
    @(negedge clk);
    drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
    sent = 0;
    got = 0;
    holding = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      if (!holding) begin
        if (sent < 20 && $urandom_range(0, 1) == 1)
          drive(1'b1, 2'b10, DW'(256 + sent), 1'b0, 1'b0);
        else
          bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", bus.out_data, DW'(0) - DW'(1));
        end else begin
          exp_d = exp_q.pop_front();
          check($sformatf("sb_data_%0d", got), bus.out_data, exp_d);
          check($sformatf("sb_ctrl_%0d", got), DW'(bus.out_ctrl), DW'(2));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        sent++;
        holding = 1'b0;
      end else begin
        holding = bus.in_valid;
      end
    end
    check("sb_all_received", DW'(got), DW'(20));
    @(negedge clk);
    drive(1'b0, 2'b00, '0, 1'b1, 1'b0);

    // saturation on the 4-bit counter instance
    drive4(1'b1, DW'(1), 1'b0);
    @(negedge clk);
    drive4(1'b1, DW'(2), 1'b0);
    @(posedge clk);
    #1;
    check("sat_full_in_ready", DW'(bus4.in_ready), DW'(0));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat_cnt_%0d", k), DW'(bus4.stall_cnt), DW'((k < 15) ? k : 15));
    end
    @(negedge clk);
    drive4(1'b0, '0, 1'b1);

    // asynchronous reset while FULL, checked before any clock edge
    drive(1'b1, 2'b11, DW'(33), 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b11, DW'(34), 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_state", DW'(dbg_state), DW'(3));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
    check("mid_rst_in_ready",  DW'(bus.in_ready),  DW'(1));
    check("mid_rst_out_ctrl",  DW'(bus.out_ctrl),  DW'(0));
    check("mid_rst_out_data",  bus.out_data,       DW'(0));
    check("mid_rst_stall_cnt", DW'(bus.stall_cnt), DW'(0));
    check("mid_rst_state",     DW'(dbg_state),     DW'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b01, DW'(51), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", DW'(bus.out_valid), DW'(1));
    check("post_rst_out_data",  bus.out_data,       DW'(51));
    @(negedge clk);
    drive(1'b0, 2'b00, '0, 1'b1, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
